// File: rtl/vga_timing.sv
//------------------------------------------------------------------------------
// Module   : vga_timing
// Purpose  : VGA raster timing generator. Produces pixel/line counters with
//            sync and blanking flags, all registered and mutually aligned.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        frame_start
);

  // Totals must fit the 11-bit counters (<= 2048 positions per axis).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] C_H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] C_H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] C_HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] C_HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] C_V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] C_V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] C_VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] C_VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vsync_q, vsync_d;
  logic        vblnk_q, vblnk_d;
  logic        fstart_q, fstart_d;
  logic        h_wrap;

  // Next counter values, and flags decoded from those next values so that
  // every registered flag describes the counter value registered alongside it.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    hsync_d  = hsync_q;
    hblnk_d  = hblnk_q;
    vsync_d  = vsync_q;
    vblnk_d  = vblnk_q;
    fstart_d = 1'b0;
    h_wrap   = (hcount_q == C_H_LAST);
    if (en) begin
      hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
      if (h_wrap) begin
        vcount_d = (vcount_q == C_V_LAST) ? 11'd0 : vcount_q + 11'd1;
      end
      hblnk_d  = (hcount_d >= C_H_ACT);
      hsync_d  = (hcount_d >= C_HS_BEG) && (hcount_d < C_HS_END);
      vblnk_d  = (vcount_d >= C_V_ACT);
      vsync_d  = (vcount_d >= C_VS_BEG) && (vcount_d < C_VS_END);
      // Only a genuine wrap into (0,0) marks a new frame; reset does not.
      fstart_d = h_wrap && (vcount_q == C_V_LAST);
    end
  end

  // Timing state register; reset clears everything regardless of en.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      hcount_q <= 11'd0;
      vcount_q <= 11'd0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      hblnk_q  <= hblnk_d;
      vsync_q  <= vsync_d;
      vblnk_q  <= vblnk_d;
      fstart_q <= fstart_d;
    end
  end

  assign hcount_out  = hcount_q;
  assign vcount_out  = vcount_q;
  assign hsync_out   = hsync_q;
  assign hblnk_out   = hblnk_q;
  assign vsync_out   = vsync_q;
  assign vblnk_out   = vblnk_q;
  assign frame_start = fstart_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
//------------------------------------------------------------------------------
// Module   : tb_vga_timing
// Purpose  : Self-checking bench for vga_timing using a reduced raster so
//            whole frames fit in a short run.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing;

  localparam int HA  = 16;
  localparam int HFP = 4;
  localparam int HS  = 8;
  localparam int HBP = 4;
  localparam int VA  = 10;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FT  = HT * VT;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic        fs;
  } exp_t;

  logic        pclk;
  logic        rst_n;
  logic        en;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic        frame_start;

  exp_t sb[$];
  int   pos;
  int   edges;
  int   hs_run;
  int   fs_seen;
  int   n_assert;
  int   n_fail;

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .en         (en),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .frame_start(frame_start)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, push the model's prediction, then pop and compare.
  task automatic step(input logic r, input logic e);
    exp_t x;
    int   hh;
    int   vv;
    logic fs;
    rst_n = r;
    en    = e;
    fs    = 1'b0;
    if (!r) begin
      pos = 0;
    end else if (e) begin
      pos = (pos + 1) % FT;
      fs  = (pos == 0);
    end
    hh   = pos % HT;
    vv   = pos / HT;
    x.h  = 11'(hh);
    x.v  = 11'(vv);
    x.hb = (!r) ? 1'b0 : (hh >= HA);
    x.hs = (!r) ? 1'b0 : ((hh >= HA + HFP) && (hh < HA + HFP + HS));
    x.vb = (!r) ? 1'b0 : (vv >= VA);
    x.vs = (!r) ? 1'b0 : ((vv >= VA + VFP) && (vv < VA + VFP + VS));
    x.fs = fs;
    sb.push_back(x);
    @(posedge pclk);
    #1;
    x = sb.pop_front();
    chk("hcount", 32'(hcount_out), 32'(x.h));
    chk("vcount", 32'(vcount_out), 32'(x.v));
    chk("hsync", 32'(hsync_out), 32'(x.hs));
    chk("hblnk", 32'(hblnk_out), 32'(x.hb));
    chk("vsync", 32'(vsync_out), 32'(x.vs));
    chk("vblnk", 32'(vblnk_out), 32'(x.vb));
    chk("frame_start", 32'(frame_start), 32'(x.fs));
    if (!r) begin
      edges  = 0;
      hs_run = 0;
    end else if (e) begin
      edges++;
      if (hsync_out === 1'b1) begin
        hs_run++;
      end else if (hs_run != 0) begin
        chk("hsync_width", 32'(hs_run), 32'(HS));
        hs_run = 0;
      end
      if (frame_start === 1'b1) begin
        fs_seen++;
        chk("frame_period", 32'(edges), 32'(FT));
        edges = 0;
      end
    end
  endtask

  // Advance with en=1 until the model reaches (th,tv), bounded by one frame.
  task automatic run_to(input int th, input int tv);
    int guard;
    guard = 0;
    while (!((pos % HT == th) && (pos / HT == tv))) begin
      step(1'b1, 1'b1);
      guard++;
      if (guard > FT) begin
        n_assert++;
        n_fail++;
        $error("FAIL run_to_timeout: observed %0d steps expected <= %0d", guard, FT);
        break;
      end
    end
  endtask

  initial begin
    pclk     = 1'b0;
    rst_n    = 1'b0;
    en       = 1'b0;
    pos      = 0;
    edges    = 0;
    hs_run   = 0;
    fs_seen  = 0;
    n_assert = 0;
    n_fail   = 0;

    // Reset, including with en high: all outputs zero.
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Release: count starts at (1,0), no frame_start pulse.
    step(1'b1, 1'b1);
    chk("release_h", 32'(hcount_out), 32'd1);
    chk("release_fs", 32'(frame_start), 32'd0);

    // Active/blank boundary on the first line.
    run_to(HA - 1, 0);
    chk("hblnk_last_active", 32'(hblnk_out), 32'd0);
    step(1'b1, 1'b1);
    chk("hblnk_first_blank", 32'(hblnk_out), 32'd1);

    // Freeze just before hsync; it must rise only once en returns.
    run_to(HA + HFP - 1, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("frozen_h", 32'(hcount_out), 32'(HA + HFP - 1));
    chk("frozen_hsync", 32'(hsync_out), 32'd0);
    step(1'b1, 1'b1);
    chk("hsync_rise", 32'(hsync_out), 32'd1);

    // Line wrap: vcount steps, blanking clears.
    run_to(HT - 1, 0);
    step(1'b1, 1'b1);
    chk("wrap_v", 32'(vcount_out), 32'd1);
    chk("wrap_hblnk", 32'(hblnk_out), 32'd0);

    // Two full frames with period and sync-width monitoring.
    for (int i = 0; i < 2 * FT; i++) step(1'b1, 1'b1);
    chk("frame_pulses", 32'(fs_seen), 32'd2);

    // Reset mid-frame with both syncs high.
    run_to(HA + HFP + 2, VA + VFP + 1);
    chk("pre_rst_hsync", 32'(hsync_out), 32'd1);
    chk("pre_rst_vsync", 32'(vsync_out), 32'd1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("restart_h", 32'(hcount_out), 32'd1);
    chk("restart_v", 32'(vcount_out), 32'd0);
    fs_seen = 0;
    for (int i = 0; i < FT - 1; i++) step(1'b1, 1'b1);
    chk("first_fs_after_rst", 32'(fs_seen), 32'd1);

    // Random enable pattern.
    for (int i = 0; i < 400; i++) step(1'b1, 1'($urandom_range(0, 3) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, 800, visible pixels per line.
REQ-002 Parameter H_FP, 40, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 128, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 88, horizontal back porch in pixels (H_TOTAL = 1056).
REQ-005 Parameter V_ACTIVE, 600, visible lines per frame.
REQ-006 Parameter V_FP, 1, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 4, vertical sync width in lines.
REQ-008 Parameter V_BP, 23, vertical back porch in lines (V_TOTAL = 628).
REQ-009 pclk  input  1  pixel clock; all logic is on the rising edge; single clock domain.
REQ-010 rst_n  input  1  reset, synchronous and active-low.
REQ-011 en  input  1  pixel advance enable; 0 freezes the timing state.
REQ-012 hcount_out  output  11  current pixel column, 0..H_TOTAL-1.
REQ-013 vcount_out  output  11  current line, 0..V_TOTAL-1.
REQ-014 hsync_out  output  1  horizontal sync, active-high.
REQ-015 hblnk_out  output  1  horizontal blanking, 1 outside the visible columns.
REQ-016 vsync_out  output  1  vertical sync, active-high.
REQ-017 vblnk_out  output  1  vertical blanking, 1 outside the visible lines.
REQ-018 frame_start  output  1  one-cycle pulse when the counters reach (0,0).

Function
REQ-019 All outputs SHALL be registered, with the next values computed combinationally from the next counter values, so every flag is aligned with the hcount_out/vcount_out value it describes (zero skew between counters and flags).
REQ-020 With en=1, hcount_out SHALL increment by 1 per pclk and wrap from H_TOTAL-1 to 0.
REQ-021 vcount_out SHALL increment only in the cycle in which hcount_out wraps to 0, and SHALL wrap from V_TOTAL-1 to 0 in that same cycle.
REQ-022 hblnk_out SHALL be 1 iff hcount_out >= H_ACTIVE; vblnk_out SHALL be 1 iff vcount_out >= V_ACTIVE.
REQ-023 hsync_out SHALL be 1 iff H_ACTIVE+H_FP <= hcount_out < H_ACTIVE+H_FP+H_SYNC (840..967 at defaults).
REQ-024 vsync_out SHALL be 1 iff V_ACTIVE+V_FP <= vcount_out < V_ACTIVE+V_FP+V_SYNC (601..604 at defaults).
REQ-025 frame_start SHALL be 1 for exactly the one enabled cycle in which hcount_out=0 and vcount_out=0 following a wrap, and 0 otherwise.
REQ-026 With en=0, all counters and flags SHALL hold their values, and frame_start SHALL be 0.
REQ-027 Counter comparisons SHALL use the full 11-bit width with no truncation; H_TOTAL and V_TOTAL SHALL both be <= 2048.
REQ-028 The outputs are a stream of timing signals consumed by downstream pipeline stages; the block SHALL have no backpressure input.

Reset
REQ-029 When rst_n=0 at a pclk edge, every output SHALL become 0, overriding en.
REQ-030 At the first pclk edge with rst_n=1 and en=1, hcount_out SHALL become 1 and vcount_out SHALL remain 0.
REQ-031 frame_start SHALL NOT pulse on reset exit; the first pulse SHALL occur at the first frame wrap.
REQ-032 Reset asserted mid-frame SHALL return the block to (0,0) on that edge, with no partial sync pulse held over.

Verification
REQ-033 Release reset with en=1 -> hcount_out sequence 0,1,2,...; when hcount_out=799, hblnk_out=0; when hcount_out=800, hblnk_out=1 in the same cycle.
REQ-034 Run one line -> hsync_out=1 exactly for hcount_out 840..967 (128 cycles); at 1055->0, vcount_out increments by 1 and hblnk_out returns to 0.
REQ-035 Run a full frame -> vsync_out=1 for vcount_out 601..604; vblnk_out=1 for 600..627; at (1055,627)->(0,0), frame_start=1 for one cycle; the count is 663168 cycles per frame.
REQ-036 Drop en to 0 for 5 cycles at hcount_out=839 -> all outputs frozen, and hsync_out rises only on the first enabled cycle after en returns.
REQ-037 Assert rst_n=0 at (900,602) with both syncs high -> all outputs 0 on that edge; after release the count restarts at (1,0), and the first frame_start occurs 663167 cycles later.
